run_detect: RTL and testbench

RUN_DETECT -- requirements
Module: run_detect

---
 rtl/run_detect.sv | 86 ++++++++
 tb/tb_run_detect.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/run_detect.sv
// Multi-channel run-length detector with per-channel saturating counters.
// Optional sticky hit flags are enabled by defining RUN_DETECT_STICKY_EN.
module run_detect #(
    parameter int CH    = 4,
    parameter int CNT_W = 4,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    in,
    input  logic [CNT_W-1:0] thresh,
`ifdef RUN_DETECT_STICKY_EN
    input  logic [CH-1:0]    clr,
    output logic [CH-1:0]    sticky,
`endif
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    level,
    output logic [CH-1:0]    hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CH-1:0]    in_q;
    logic [CH-1:0]    out_d_q;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];

    // Next run length per channel: extend, saturate, or restart the run
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (MODE == 0) begin
                if (!in[i])
                    cnt_d[i] = '0;
                else if (cnt_q[i] != CNT_MAX)
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                if (in[i] != in_q[i])
                    cnt_d[i] = CNT_ONE;
                else if (cnt_q[i] != CNT_MAX)
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Threshold compare is combinational so a new thresh applies at once
    always_comb begin
        out = '0;
        for (int i = 0; i < CH; i++)
            out[i] = (cnt_q[i] >= thresh) && (thresh != '0);
    end

    assign hit   = out & ~out_d_q;
    assign level = in_q;

    // Sample input, advance counters and remember out for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q    <= '0;
            out_d_q <= '0;
            for (int i = 0; i < CH; i++)
                cnt_q[i] <= '0;
        end else begin
            in_q    <= in;
            out_d_q <= out;
            for (int i = 0; i < CH; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef RUN_DETECT_STICKY_EN
    logic [CH-1:0] sticky_q;

    // Sticky flag: set by a hit, cleared by clr, set wins on collision
    always_ff @(posedge clk) begin
        if (reset)
            sticky_q <= '0;
        else
            sticky_q <= (sticky_q & ~clr) | hit;
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_run_detect.sv
// Randomized and directed bench for run_detect against a run-length model.
// Checks a MODE 0 and a MODE 1 instance driven by the same input bits.
module tb_run_detect;

    localparam int CH = 4;
    localparam int W0 = 4;
    localparam int W1 = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] in;
    logic [W0-1:0] th0;
    logic [W1-1:0] th1;
    logic [CH-1:0] out0, lvl0, hit0;
    logic [CH-1:0] out1, lvl1, hit1;
`ifdef RUN_DETECT_STICKY_EN
    logic [CH-1:0] clr;
    logic [CH-1:0] stk0, stk1;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Model state: unbounded run lengths, last sample, previous out, sticky
    int            run0 [CH];
    int            run1 [CH];
    logic [CH-1:0] last1;
    logic [CH-1:0] lastin;
    logic [CH-1:0] od0, od1;
    logic [CH-1:0] sk0, sk1;

    always #5 clk = ~clk;

    run_detect #(.CH(CH), .CNT_W(W0), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in(in), .thresh(th0),
`ifdef RUN_DETECT_STICKY_EN
        .clr(clr), .sticky(stk0),
`endif
        .out(out0), .level(lvl0), .hit(hit0)
    );

    run_detect #(.CH(CH), .CNT_W(W1), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in(in), .thresh(th1),
`ifdef RUN_DETECT_STICKY_EN
        .clr(clr), .sticky(stk1),
`endif
        .out(out1), .level(lvl1), .hit(hit1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // A channel is over threshold when its true run length reaches thresh
    function automatic logic [CH-1:0] mout(input int r [CH], input int th);
        logic [CH-1:0] m;
        m = '0;
        for (int i = 0; i < CH; i++)
            m[i] = (th != 0) && (r[i] >= th);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            run0[i] = 0;
            run1[i] = 0;
        end
        last1  = '0;
        lastin = '0;
        od0    = '0;
        od1    = '0;
        sk0    = '0;
        sk1    = '0;
    endtask

    task automatic check_cycle();
        logic [CH-1:0] e0, e1;
        e0 = mout(run0, int'(th0));
        e1 = mout(run1, int'(th1));
        chk("out0", 32'(out0), 32'(e0));
        chk("hit0", 32'(hit0), 32'(e0 & ~od0));
        chk("lvl0", 32'(lvl0), 32'(lastin));
        chk("out1", 32'(out1), 32'(e1));
        chk("hit1", 32'(hit1), 32'(e1 & ~od1));
        chk("lvl1", 32'(lvl1), 32'(last1));
`ifdef RUN_DETECT_STICKY_EN
        chk("stk0", 32'(stk0), 32'(sk0));
        chk("stk1", 32'(stk1), 32'(sk1));
`endif
    endtask

    task automatic model_edge();
        logic [CH-1:0] e0, e1;
        logic [CH-1:0] c;
        e0 = mout(run0, int'(th0));
        e1 = mout(run1, int'(th1));
        c  = '0;
`ifdef RUN_DETECT_STICKY_EN
        c  = clr;
`endif
        if (reset) begin
            model_reset();
        end else begin
            sk0 = (sk0 & ~c) | (e0 & ~od0);
            sk1 = (sk1 & ~c) | (e1 & ~od1);
            od0 = e0;
            od1 = e1;
            for (int i = 0; i < CH; i++) begin
                run0[i] = in[i] ? run0[i] + 1 : 0;
                run1[i] = (in[i] == last1[i]) ? run1[i] + 1 : 1;
            end
            last1  = in;
            lastin = in;
        end
    endtask

    task automatic step(input logic [CH-1:0] iv, input int t0, input int t1,
                        input logic r, input logic [CH-1:0] c);
        @(negedge clk);
        in    = iv;
        th0   = W0'(t0);
        th1   = W1'(t1);
        reset = r;
`ifdef RUN_DETECT_STICKY_EN
        clr   = c;
`endif
        #1;
        check_cycle();
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        logic [CH-1:0] iv;
        logic [CH-1:0] c;
        int t0, t1;
        in    = '0;
        th0   = '0;
        th1   = '0;
        reset = 1'b1;
`ifdef RUN_DETECT_STICKY_EN
        clr   = '0;
`endif
        repeat (2) @(posedge clk);
        model_reset();

        // Single channel run of six ones against thresh 4
        for (int k = 0; k < 9; k++)
            step((k < 6) ? 4'b0001 : 4'b0000, 4, 3, 1'b0, 4'b0000);

        // Interrupted run on channel 1 against thresh 3
        step('0, 3, 3, 1'b1, '0);
        iv = '0;
        for (int k = 0; k < 8; k++) begin
            iv[1] = (k == 2 || k > 5) ? 1'b0 : 1'b1;
            step(iv, 3, 3, 1'b0, 4'b0000);
        end

        // Level run 0,0,0,1,1,1 on channel 2 for the stable-level instance
        step('0, 3, 3, 1'b1, '0);
        iv = '0;
        for (int k = 0; k < 8; k++) begin
            iv[2] = (k >= 3 && k < 6) ? 1'b1 : 1'b0;
            step(iv, 3, 3, 1'b0, 4'b0000);
        end

        // Long run to saturate both counters, then disable via thresh 0
        for (int k = 0; k < 20; k++)
            step(4'b1000, 15, 7, 1'b0, 4'b0000);
        step(4'b1000, 0, 0, 1'b0, 4'b0000);
        step(4'b1000, 0, 0, 1'b0, 4'b0000);
        // Lowering thresh from disabled re-raises out and produces a hit
        step(4'b1000, 3, 3, 1'b0, 4'b0000);
        step(4'b1000, 3, 3, 1'b0, 4'b0000);

        // Sticky set and clear on channel 0 with clr coinciding on the hit
        step('0, 4, 3, 1'b1, '0);
        for (int k = 0; k < 8; k++)
            step(4'b0001, 4, 3, 1'b0, (k == 4 || k == 6) ? 4'b0001 : 4'b0000);

        // Reset aborts a run of three, then counting restarts from zero
        step('0, 4, 4, 1'b1, '0);
        for (int k = 0; k < 3; k++)
            step(4'b1111, 4, 4, 1'b0, 4'b0000);
        step(4'b1111, 4, 4, 1'b1, 4'b0000);
        for (int k = 0; k < 6; k++)
            step(4'b1111, 4, 4, 1'b0, 4'b0000);

        // Randomized traffic with biased ones and occasional thresh moves
        t0 = 4;
        t1 = 3;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++)
                iv[i] = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0)
                t0 = $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0)
                t1 = $urandom_range(0, 7);
            c = CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15));
            step(iv, t0, t1, ($urandom_range(0, 49) == 0), c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
